// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record/playback SRAM controller.
package aud_pkg;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned STATE_W = 3;

  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } aud_state_e;

endpackage

// File: rtl/aud_key_ctrl.sv
// Key priority resolution (stop > pause > start) and codec LR-clock edge detection.
module aud_key_ctrl (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_start,
  input  logic i_key_pause,
  input  logic i_key_stop,
  input  logic i_lrc,
  output logic o_start_c,
  output logic o_pause_c,
  output logic o_stop_c,
  output logic o_lrc_rise_c,
  output logic o_lrc_fall_c
);

  logic lrc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q <= 1'b0;
    end else begin
      lrc_q <= i_lrc;
    end
  end

  assign o_stop_c     = i_key_stop;
  assign o_pause_c    = i_key_pause & ~i_key_stop;
  assign o_start_c    = i_key_start & ~i_key_pause & ~i_key_stop;
  assign o_lrc_rise_c = ~lrc_q & i_lrc;
  assign o_lrc_fall_c = lrc_q & ~i_lrc;

endmodule

// File: rtl/aud_sram_ctrl.sv
// Record/playback sequencer and single-port SRAM arbiter for the audio path.
// Build option: define AUD_LOOP_PLAY_EN to make playback wrap to address 0 at the end of the recording.
module aud_sram_ctrl
  import aud_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_key_start,
  input  logic               i_key_pause,
  input  logic               i_key_stop,
  input  logic               i_mode,
  input  logic               i_lrc,
  output logic               o_rec_start,
  output logic               o_rec_pause,
  output logic               o_rec_stop,
  input  logic [ADDR_W-1:0]  i_rec_addr,
  input  logic [DATA_W-1:0]  i_rec_data,
  output logic               o_ply_start,
  output logic               o_ply_pause,
  output logic               o_ply_stop,
  output logic [DATA_W-1:0]  o_ply_data,
  output logic               o_ply_valid,
  output logic [ADDR_W-1:0]  o_sram_addr,
  output logic [DATA_W-1:0]  o_sram_wdata,
  input  logic [DATA_W-1:0]  i_sram_rdata,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic [ADDR_W-1:0]  o_end_addr,
  output logic [STATE_W-1:0] o_state
);

  logic start_c, pause_c, stop_c, lrc_rise_c, lrc_fall_c;

  aud_key_ctrl u_key_ctrl (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key_start  (i_key_start),
    .i_key_pause  (i_key_pause),
    .i_key_stop   (i_key_stop),
    .i_lrc        (i_lrc),
    .o_start_c    (start_c),
    .o_pause_c    (pause_c),
    .o_stop_c     (stop_c),
    .o_lrc_rise_c (lrc_rise_c),
    .o_lrc_fall_c (lrc_fall_c)
  );

  aud_state_e state_q, state_d;

  logic              rec_start_q, rec_start_d;
  logic              rec_pause_q, rec_pause_d;
  logic              rec_stop_q,  rec_stop_d;
  logic              ply_start_q, ply_start_d;
  logic              ply_pause_q, ply_pause_d;
  logic              ply_stop_q,  ply_stop_d;
  logic              ply_valid_q, ply_valid_d;
  logic [DATA_W-1:0] ply_data_q,  ply_data_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              we_n_q,      we_n_d;
  logic              oe_n_q,      oe_n_d;
  logic [ADDR_W-1:0] end_addr_q,  end_addr_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic              has_rec_q,   has_rec_d;

  // Keys take precedence over a coincident lrc edge.
  logic wr_c, rd_c, play_end_c, play_ok_c, rec_full_c;

  assign wr_c       = (state_q == S_REC)  & ~stop_c & ~pause_c & lrc_rise_c;
  assign rd_c       = (state_q == S_PLAY) & ~stop_c & ~pause_c & lrc_fall_c;
  assign play_end_c = rd_c & (ptr_q == end_addr_q);
  assign rec_full_c = wr_c & (i_rec_addr == MAX_ADDR);
  assign play_ok_c  = (end_addr_q != '0) | has_rec_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      ply_start_q <= 1'b0;
      ply_pause_q <= 1'b0;
      ply_stop_q  <= 1'b0;
      ply_valid_q <= 1'b0;
      ply_data_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      end_addr_q  <= '0;
      ptr_q       <= '0;
      has_rec_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_start_q <= rec_start_d;
      rec_pause_q <= rec_pause_d;
      rec_stop_q  <= rec_stop_d;
      ply_start_q <= ply_start_d;
      ply_pause_q <= ply_pause_d;
      ply_stop_q  <= ply_stop_d;
      ply_valid_q <= ply_valid_d;
      ply_data_q  <= ply_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      end_addr_q  <= end_addr_d;
      ptr_q       <= ptr_d;
      has_rec_q   <= has_rec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (!i_mode)        state_d = S_REC;
          else if (play_ok_c) state_d = S_PLAY;
        end
      end
      S_REC: begin
        if (stop_c)          state_d = S_IDLE;
        else if (pause_c)    state_d = S_REC_PAUSE;
        else if (rec_full_c) state_d = S_IDLE;
      end
      S_REC_PAUSE: begin
        if (stop_c)       state_d = S_IDLE;
        else if (start_c) state_d = S_REC;
      end
      S_PLAY: begin
        if (stop_c)          state_d = S_IDLE;
        else if (pause_c)    state_d = S_PLAY_PAUSE;
`ifndef AUD_LOOP_PLAY_EN
        else if (play_end_c) state_d = S_IDLE;
`endif
      end
      S_PLAY_PAUSE: begin
        if (stop_c)       state_d = S_IDLE;
        else if (start_c) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    ply_start_d = 1'b0;
    ply_pause_d = 1'b0;
    ply_stop_d  = 1'b0;
    ply_valid_d = 1'b0;
    ply_data_d  = ply_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    end_addr_d  = end_addr_q;
    ptr_d       = ptr_q;
    has_rec_d   = has_rec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (!i_mode) begin
            rec_start_d = 1'b1;
            end_addr_d  = '0;
          end else if (play_ok_c) begin
            ply_start_d = 1'b1;
            ptr_d       = '0;
          end
        end
      end
      S_REC: begin
        if (stop_c) begin
          rec_stop_d = 1'b1;
        end else if (pause_c) begin
          rec_pause_d = 1'b1;
        end else if (wr_c) begin
          addr_d     = i_rec_addr;
          wdata_d    = i_rec_data;
          we_n_d     = 1'b0;
          end_addr_d = i_rec_addr;
          has_rec_d  = 1'b1;
          rec_stop_d = rec_full_c;
        end
      end
      S_REC_PAUSE: begin
        if (stop_c)       rec_stop_d  = 1'b1;
        else if (start_c) rec_start_d = 1'b1;
      end
      S_PLAY: begin
        if (stop_c) begin
          ply_stop_d = 1'b1;
        end else if (pause_c) begin
          ply_pause_d = 1'b1;
        end else if (rd_c) begin
          ply_data_d  = i_sram_rdata;
          ply_valid_d = 1'b1;
          if (play_end_c) begin
`ifdef AUD_LOOP_PLAY_EN
            ptr_d = '0;
`else
            ply_stop_d = 1'b1;
`endif
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      S_PLAY_PAUSE: begin
        if (stop_c)       ply_stop_d  = 1'b1;
        else if (start_c) ply_start_d = 1'b1;
      end
      default: ;
    endcase
    // Read port is enabled only while playing, which also keeps it exclusive of writes.
    oe_n_d = (state_d != S_PLAY);
    if (state_d == S_PLAY) addr_d = ptr_d;
  end

  assign o_state      = state_q;
  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_ply_start  = ply_start_q;
  assign o_ply_pause  = ply_pause_q;
  assign o_ply_stop   = ply_stop_q;
  assign o_ply_valid  = ply_valid_q;
  assign o_ply_data   = ply_data_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_end_addr   = end_addr_q;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// Directed scoreboard bench for aud_sram_ctrl; honours AUD_LOOP_PLAY_EN when defined.
module tb_aud_sram_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_key_start, i_key_pause, i_key_stop;
  logic        i_mode;
  logic        i_lrc;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic [19:0] i_rec_addr;
  logic [15:0] i_rec_data;
  logic        o_ply_start, o_ply_pause, o_ply_stop;
  logic [15:0] o_ply_data;
  logic        o_ply_valid;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic [15:0] i_sram_rdata;
  logic        o_sram_we_n, o_sram_oe_n;
  logic [19:0] o_end_addr;
  logic [2:0]  o_state;

  aud_sram_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key_start  (i_key_start),
    .i_key_pause  (i_key_pause),
    .i_key_stop   (i_key_stop),
    .i_mode       (i_mode),
    .i_lrc        (i_lrc),
    .o_rec_start  (o_rec_start),
    .o_rec_pause  (o_rec_pause),
    .o_rec_stop   (o_rec_stop),
    .i_rec_addr   (i_rec_addr),
    .i_rec_data   (i_rec_data),
    .o_ply_start  (o_ply_start),
    .o_ply_pause  (o_ply_pause),
    .o_ply_stop   (o_ply_stop),
    .o_ply_data   (o_ply_data),
    .o_ply_valid  (o_ply_valid),
    .o_sram_addr  (o_sram_addr),
    .o_sram_wdata (o_sram_wdata),
    .i_sram_rdata (i_sram_rdata),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_end_addr   (o_end_addr),
    .o_state      (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // SRAM model: every location reads back as 0xA000 + address, one cycle after the address.
  always @(posedge i_clk) i_sram_rdata <= 16'hA000 + o_sram_addr[15:0];

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int nval   = 0;
  int base;
  logic [35:0] wq[$];
  logic [15:0] pq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check SRAM strobes and playback strobes against the scoreboard.
  task automatic tick();
    logic [35:0] ew;
    logic [15:0] ep;
    @(posedge i_clk);
    #1;
    chk("we_oe_exclusive", 32'(o_sram_we_n | o_sram_oe_n), 32'd1);
    if (!o_sram_we_n) begin
      nwr++;
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("wr_addr", 32'(o_sram_addr), 32'(ew[35:16]));
        chk("wr_data", 32'(o_sram_wdata), 32'(ew[15:0]));
      end
    end
    if (o_ply_valid) begin
      nval++;
      chk("strobe_expected", 32'(pq.size() != 0), 32'd1);
      if (pq.size() != 0) begin
        ep = pq.pop_front();
        chk("ply_data", 32'(o_ply_data), 32'(ep));
      end
    end
  endtask

  task automatic press(input logic st, input logic pa, input logic sp);
    i_key_start = st;
    i_key_pause = pa;
    i_key_stop  = sp;
    tick();
    i_key_start = 1'b0;
    i_key_pause = 1'b0;
    i_key_stop  = 1'b0;
  endtask

  task automatic lrc_rise(input logic [19:0] a, input logic [15:0] d, input logic expect_wr);
    i_rec_addr = a;
    i_rec_data = d;
    if (expect_wr) wq.push_back({a, d});
    i_lrc = 1'b1;
    tick();
  endtask

  task automatic lrc_finish_high();
    repeat (3) tick();
    i_lrc = 1'b0;
    repeat (4) tick();
  endtask

  // High phase then the falling edge; returns right after the edge that sees the fall.
  task automatic lrc_fall();
    i_lrc = 1'b1;
    repeat (4) tick();
    i_lrc = 1'b0;
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_key_start = 1'b0;
    i_key_pause = 1'b0;
    i_key_stop = 1'b0;
    i_mode = 1'b0;
    i_lrc = 1'b0;
    i_rec_addr = '0;
    i_rec_data = '0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(o_sram_oe_n), 32'd1);
    chk("rst_end_addr", 32'(o_end_addr), 32'd0);
    chk("rst_sram_addr", 32'(o_sram_addr), 32'd0);

    // Play start with nothing recorded since reset is ignored.
    i_mode = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    chk("noplay_start_pulse", 32'(o_ply_start), 32'd0);
    chk("noplay_state", 32'(o_state), 32'd0);
    chk("noplay_oe_n", 32'(o_sram_oe_n), 32'd1);

    // Test 1: reset while a write strobe is active.
    i_mode = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    chk("t1_rec_start", 32'(o_rec_start), 32'd1);
    chk("t1_state_rec", 32'(o_state), 32'd1);
    tick();
    lrc_rise(20'd5, 16'h1234, 1'b1);
    chk("t1_we_low", 32'(o_sram_we_n), 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("t1_state", 32'(o_state), 32'd0);
    chk("t1_we_n", 32'(o_sram_we_n), 32'd1);
    chk("t1_oe_n", 32'(o_sram_oe_n), 32'd1);
    chk("t1_addr", 32'(o_sram_addr), 32'd0);
    chk("t1_wdata", 32'(o_sram_wdata), 32'd0);
    chk("t1_end_addr", 32'(o_end_addr), 32'd0);
    chk("t1_ply_data", 32'(o_ply_data), 32'd0);
    chk("t1_pulses", 32'({o_rec_start, o_rec_pause, o_rec_stop, o_ply_start,
                          o_ply_pause, o_ply_stop, o_ply_valid}), 32'd0);
    i_lrc = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // Test 2: record four words.
    base = nwr;
    i_mode = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    chk("t2_rec_start", 32'(o_rec_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      lrc_rise(20'(i), 16'hA000 + 16'(i), 1'b1);
      lrc_finish_high();
    end
    chk("t2_write_count", 32'(nwr - base), 32'd4);
    chk("t2_wq_drained", 32'(wq.size()), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    chk("t2_rec_stop", 32'(o_rec_stop), 32'd1);
    chk("t2_state", 32'(o_state), 32'd0);
    chk("t2_end_addr", 32'(o_end_addr), 32'd3);

    // Test 3: play the recording back.
    base = nval;
    i_mode = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    chk("t3_ply_start", 32'(o_ply_start), 32'd1);
    chk("t3_state", 32'(o_state), 32'd3);
    chk("t3_oe_n", 32'(o_sram_oe_n), 32'd0);
    for (int k = 0; k < 4; k++) begin
      pq.push_back(16'hA000 + 16'(k));
      lrc_fall();
`ifndef AUD_LOOP_PLAY_EN
      if (k == 3) begin
        chk("t3_end_stop", 32'(o_ply_stop), 32'd1);
        chk("t3_end_state", 32'(o_state), 32'd0);
        chk("t3_end_oe_n", 32'(o_sram_oe_n), 32'd1);
      end
`endif
      repeat (3) tick();
    end
`ifdef AUD_LOOP_PLAY_EN
    pq.push_back(16'hA000);
    lrc_fall();
    chk("t3_loop_no_stop", 32'(o_ply_stop), 32'd0);
    chk("t3_loop_state", 32'(o_state), 32'd3);
    repeat (3) tick();
    chk("t3_strobe_count", 32'(nval - base), 32'd5);
    press(1'b0, 1'b0, 1'b1);
    chk("t3_loop_stop", 32'(o_ply_stop), 32'd1);
`else
    lrc_fall();
    repeat (3) tick();
    chk("t3_strobe_count", 32'(nval - base), 32'd4);
`endif
    chk("t3_final_state", 32'(o_state), 32'd0);

    // Test 4: pause at address 2, idle, resume.
    press(1'b1, 1'b0, 1'b0);
    chk("t4_state_play", 32'(o_state), 32'd3);
    for (int k = 0; k < 2; k++) begin
      pq.push_back(16'hA000 + 16'(k));
      lrc_fall();
      repeat (3) tick();
    end
    press(1'b0, 1'b1, 1'b0);
    chk("t4_ply_pause", 32'(o_ply_pause), 32'd1);
    chk("t4_state_pause", 32'(o_state), 32'd4);
    chk("t4_oe_n", 32'(o_sram_oe_n), 32'd1);
    base = nval;
    for (int k = 0; k < 10; k++) begin
      lrc_fall();
      repeat (3) tick();
    end
    chk("t4_no_strobes", 32'(nval - base), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    chk("t4_resume_start", 32'(o_ply_start), 32'd1);
    chk("t4_resume_state", 32'(o_state), 32'd3);
    chk("t4_resume_addr", 32'(o_sram_addr), 32'd2);
    pq.push_back(16'hA002);
    lrc_fall();
    chk("t4_resume_valid", 32'(o_ply_valid), 32'd1);
    repeat (3) tick();
    press(1'b0, 1'b0, 1'b1);
    chk("t4_stop", 32'(o_ply_stop), 32'd1);
    chk("t4_state_idle", 32'(o_state), 32'd0);

    // Test 5: all keys plus an lrc rise in the same cycle during recording.
    i_mode = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    chk("t5_end_cleared", 32'(o_end_addr), 32'd0);
    tick();
    base = nwr;
    i_rec_addr = 20'd7;
    i_rec_data = 16'h5555;
    i_lrc = 1'b1;
    press(1'b1, 1'b1, 1'b1);
    chk("t5_pulses", 32'({o_rec_start, o_rec_pause, o_rec_stop}), 32'b001);
    chk("t5_state", 32'(o_state), 32'd0);
    chk("t5_no_write", 32'(nwr - base), 32'd0);
    i_lrc = 1'b0;
    repeat (2) tick();
    chk("t5_end_addr", 32'(o_end_addr), 32'd0);

    // Test 6: write at the last address ends the recording.
    press(1'b1, 1'b0, 1'b0);
    tick();
    lrc_rise(20'hFFFFF, 16'hBEEF, 1'b1);
    chk("t6_we_low", 32'(o_sram_we_n), 32'd0);
    chk("t6_rec_stop", 32'(o_rec_stop), 32'd1);
    chk("t6_state", 32'(o_state), 32'd0);
    chk("t6_end_addr", 32'(o_end_addr), 32'hFFFFF);
    tick();
    chk("t6_we_high", 32'(o_sram_we_n), 32'd1);
    chk("t6_stop_single", 32'(o_rec_stop), 32'd0);
    i_lrc = 1'b0;
    repeat (2) tick();
    chk("final_wq_empty", 32'(wq.size()), 32'd0);
    chk("final_pq_empty", 32'(pq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
